// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters. It produces a registered one-hot grant
// and its binary index, holds the grant until the owner releases it or the hold
// limit is reached, and then rotates priority past the last owner.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  // Count value seen on the last allowed grant cycle. With MAX_HOLD=0 this
  // wraps to all ones, but hold_hit is gated off in that case.
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_HOLD - 1);
  localparam logic             HOLD_EN = (MAX_HOLD != 0);

  state_t           state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic       win_found;
  logic [2:0] win_idx;
  logic       owner_req;
  logic       hold_hit;
  logic       release_now;

  // Scan from ptr upward, modulo 8. The loop runs backward so that the
  // closest requester after ptr is written last and wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    for (int k = 7; k >= 0; k--) begin
      if (req[ptr + 3'(k)]) begin
        win_found = 1'b1;
        win_idx   = ptr + 3'(k);
      end
    end
  end

  assign owner_req   = req[gnt_idx];
  assign hold_hit    = HOLD_EN && (cnt == LIMIT);
  assign release_now = done || !owner_req || hold_hit;

  // Arbiter FSM. All outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      cnt       <= '0;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (win_found) begin
            state     <= GRANT;
            gnt_valid <= 1'b1;
            gnt_idx   <= win_idx;
            gnt       <= 8'b1 << win_idx;
            cnt       <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state     <= RELEASE;
            gnt       <= 8'h00;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 3'd1;
            cnt       <= '0;
            // Flag a timeout only when the hold limit alone ended the grant.
            timeout   <= hold_hit && !done && owner_req;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          // One dead cycle. Requests are not sampled here.
          timeout <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state     <= IDLE;
          gnt       <= 8'h00;
          gnt_valid <= 1'b0;
          timeout   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed testbench for rr_arbiter8. Inputs change on the falling edge, and
// outputs are sampled on the falling edge, away from the active rising edge.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  rr_arbiter8 #(.MAX_HOLD(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] one;
    one  = 8'h01;
    rst  = 1'b1;
    req  = 8'hFF;
    done = 1'b0;

    // 1: reset holds everything low, even with all requests raised
    nxt(); nxt();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(gnt_valid), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_idx", 32'(gnt_idx), 32'h0);
    rst = 1'b0;
    req = 8'h00;
    nxt(); nxt();
    chk("idle_valid", 32'(gnt_valid), 32'h0);
    chk("idle_gnt", 32'(gnt), 32'h0);

    // 2: single requester, release on done, then ptr=4 prefers 4 over 3
    req = 8'h08;
    nxt();
    chk("single_gnt", 32'(gnt), 32'h08);
    chk("single_idx", 32'(gnt_idx), 32'd3);
    chk("single_valid", 32'(gnt_valid), 32'h1);
    done = 1'b1;
    nxt();
    chk("single_rel_gnt", 32'(gnt), 32'h0);
    chk("single_rel_valid", 32'(gnt_valid), 32'h0);
    done = 1'b0;
    req  = 8'h00;
    nxt();
    req = 8'h18;
    nxt();
    chk("ptr4_idx", 32'(gnt_idx), 32'd4);
    done = 1'b1;
    nxt();
    done = 1'b0;
    req  = 8'h00;
    nxt();

    // 3: rotation through 0..7,0 with two low cycles between grants
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      nxt();
      chk("rot_idx", 32'(gnt_idx), 32'(i % 8));
      chk("rot_gnt", 32'(gnt), 32'(one << (i % 8)));
      chk("rot_valid", 32'(gnt_valid), 32'h1);
      done = 1'b1;
      nxt();
      chk("rot_gap1", 32'(gnt_valid), 32'h0);
      done = 1'b0;
      nxt();
      chk("rot_gap2", 32'(gnt_valid), 32'h0);
    end
    req = 8'h00;

    // 4: wrap from 7 to 0 after a grant to 6
    nxt();
    req = 8'h40;
    nxt();
    chk("wrap_g6", 32'(gnt_idx), 32'd6);
    done = 1'b1;
    req  = 8'h81;
    nxt();
    done = 1'b0;
    nxt(); nxt();
    chk("wrap_g7", 32'(gnt_idx), 32'd7);
    chk("wrap_g7_gnt", 32'(gnt), 32'h80);
    done = 1'b1;
    nxt();
    done = 1'b0;
    nxt(); nxt();
    chk("wrap_g0", 32'(gnt_idx), 32'd0);
    chk("wrap_g0_gnt", 32'(gnt), 32'h01);
    done = 1'b1;
    nxt();
    done = 1'b0;
    req  = 8'h00;
    nxt();

    // 5: hold limit gives 16 grant cycles, a timeout pulse, then a regrant
    req = 8'h04;
    nxt();
    for (int i = 0; i < 16; i++) begin
      chk("hold_valid", 32'(gnt_valid), 32'h1);
      chk("hold_gnt", 32'(gnt), 32'h04);
      chk("hold_no_to", 32'(timeout), 32'h0);
      nxt();
    end
    chk("to_valid", 32'(gnt_valid), 32'h0);
    chk("to_pulse", 32'(timeout), 32'h1);
    nxt();
    chk("to_clear", 32'(timeout), 32'h0);
    chk("to_idle_valid", 32'(gnt_valid), 32'h0);
    nxt();
    chk("regrant_valid", 32'(gnt_valid), 32'h1);
    chk("regrant_idx", 32'(gnt_idx), 32'd2);

    // 6a: done and hold limit in the same cycle give no timeout
    for (int i = 1; i < 16; i++) begin
      nxt();
      chk("lim_valid", 32'(gnt_valid), 32'h1);
    end
    done = 1'b1;
    nxt();
    chk("lim_done_valid", 32'(gnt_valid), 32'h0);
    chk("lim_done_to", 32'(timeout), 32'h0);
    done = 1'b0;
    nxt(); nxt();
    chk("pre_rst_valid", 32'(gnt_valid), 32'h1);

    // 6b: reset mid-grant drops the grant at once and clears ptr
    #2 rst = 1'b1;
    #1;
    chk("async_gnt", 32'(gnt), 32'h0);
    chk("async_valid", 32'(gnt_valid), 32'h0);
    nxt();
    rst = 1'b0;
    req = 8'h24;
    nxt();
    chk("ptr0_idx", 32'(gnt_idx), 32'd2);

    // 6c: owner drops its request mid-grant, giving a release without timeout
    nxt(); nxt();
    chk("drop_pre", 32'(gnt_valid), 32'h1);
    req = 8'h00;
    nxt();
    chk("drop_valid", 32'(gnt_valid), 32'h0);
    chk("drop_to", 32'(timeout), 32'h0);
    nxt();
    chk("drop_idle", 32'(gnt_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
